// File: rtl/sb_cmd_sequencer_if.sv
// Command/response handshake plus hard-IP system-bus port of sb_cmd_sequencer.
// master = sequencer side, slave = host / hard-IP side.
interface sb_cmd_sequencer_if #(
    parameter int unsigned CH_W = 1
);
    logic            cmd_valid;
    logic            cmd_ready;
    logic [1:0]      cmd_op;
    logic [CH_W-1:0] cmd_ch;
    logic [3:0]      cmd_addr;
    logic [7:0]      cmd_data;
    logic [7:0]      cmd_mask;
    logic            rsp_valid;
    logic [7:0]      rsp_data;
    logic            rsp_err;
    logic            busy;
    logic            sbstb;
    logic            sbrw;
    logic [7:0]      sbadr;
    logic [7:0]      sbdat_o;
    logic [7:0]      sbdat_i;
    logic            sback;

    modport master (
        input  cmd_valid, cmd_op, cmd_ch, cmd_addr, cmd_data, cmd_mask, sbdat_i, sback,
        output cmd_ready, rsp_valid, rsp_data, rsp_err, busy, sbstb, sbrw, sbadr, sbdat_o
    );

    modport slave (
        output cmd_valid, cmd_op, cmd_ch, cmd_addr, cmd_data, cmd_mask, sbdat_i, sback,
        input  cmd_ready, rsp_valid, rsp_data, rsp_err, busy, sbstb, sbrw, sbadr, sbdat_o
    );
endinterface

// File: rtl/sb_cmd_sequencer.sv
// Queues write/read/poll commands and runs them one at a time on the shared hard-IP system bus.
// Define SB_SEQ_ACK_TIMEOUT_EN to abort a strobe that sees no sback within TIMEOUT_CYCLES.
module sb_cmd_sequencer #(
    parameter int unsigned         DEPTH          = 4,
    parameter int unsigned         NUM_CH         = 2,
    parameter logic [4*NUM_CH-1:0] CH_BASE        = {4'b0011, 4'b0001},
    parameter int unsigned         POLL_MAX       = 1023,
    parameter int unsigned         TIMEOUT_CYCLES = 255
) (
    input  logic               clock,
    input  logic               reset_n,
    sb_cmd_sequencer_if.master bus
);
    localparam int unsigned CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int unsigned AW   = $clog2(DEPTH);
    localparam int unsigned PC_W = $clog2(POLL_MAX + 1);
    localparam logic [1:0]  OP_WR   = 2'b00;
    localparam logic [1:0]  OP_RD   = 2'b01;
    localparam logic [1:0]  OP_POLL = 2'b10;

    typedef struct packed {
        logic [1:0]      op;
        logic [CH_W-1:0] ch;
        logic [3:0]      addr;
        logic [7:0]      data;
        logic [7:0]      mask;
    } cmd_t;

    typedef enum logic [1:0] {IDLE, STROBE, RESP, GAP} state_t;

    state_t          state_q, state_d;
    cmd_t            mem_q [DEPTH];
    cmd_t            cmd_in, head;
    logic [AW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [AW:0]     count_q, count_d;
    logic            full, empty, push, pop;
    logic [1:0]      op_q, op_d;
    logic [7:0]      match_q, match_d, mask_q, mask_d;
    logic [PC_W-1:0] poll_cnt_q, poll_cnt_d;
    logic            sbstb_q, sbstb_d, sbrw_q, sbrw_d;
    logic [7:0]      sbadr_q, sbadr_d, sbdat_o_q, sbdat_o_d;
    logic            rsp_valid_q, rsp_valid_d, rsp_err_q, rsp_err_d;
    logic [7:0]      rsp_data_q, rsp_data_d;
    logic            fire, fire_err;
    logic [7:0]      fire_data;
`ifdef SB_SEQ_ACK_TIMEOUT_EN
    localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);
    logic [TW-1:0]   tmo_cnt_q, tmo_cnt_d;
`endif

    function automatic logic [3:0] ch_base(input logic [CH_W-1:0] ch);
        logic [3:0] b;
        b = 4'h0;
        for (int unsigned k = 0; k < NUM_CH; k++) begin
            if (ch == CH_W'(k)) b = CH_BASE[4*k +: 4];
        end
        return b;
    endfunction

    assign full  = (count_q == (AW+1)'(DEPTH));
    assign empty = (count_q == '0);
    assign head  = mem_q[rd_ptr_q];

    // FIFO bookkeeping; a pop at full frees no slot for the same edge since ready is already low
    always_comb begin
        cmd_in   = {bus.cmd_op, bus.cmd_ch, bus.cmd_addr, bus.cmd_data, bus.cmd_mask};
        push     = bus.cmd_valid && !full;
        wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d = pop ? rd_ptr_q + AW'(1) : rd_ptr_q;
        count_d  = count_q + (AW+1)'(push) - (AW+1)'(pop);
    end

    always_ff @(posedge clock) begin
        if (push) mem_q[wr_ptr_q] <= cmd_in;
    end

    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        match_d     = match_q;
        mask_d      = mask_q;
        poll_cnt_d  = poll_cnt_q;
        sbstb_d     = sbstb_q;
        sbrw_d      = sbrw_q;
        sbadr_d     = sbadr_q;
        sbdat_o_d   = sbdat_o_q;
        rsp_valid_d = 1'b0;
        rsp_data_d  = rsp_data_q;
        rsp_err_d   = rsp_err_q;
        pop         = 1'b0;
        fire        = 1'b0;
        fire_err    = 1'b0;
        fire_data   = 8'h00;
`ifdef SB_SEQ_ACK_TIMEOUT_EN
        tmo_cnt_d   = '0;
`endif
        unique case (state_q)
            IDLE: begin
                if (!empty) begin
                    pop        = 1'b1;
                    op_d       = head.op;
                    match_d    = head.data;
                    mask_d     = head.mask;
                    poll_cnt_d = '0;
                    if (head.op == 2'b11 || 32'(head.ch) >= NUM_CH) begin
                        fire     = 1'b1;
                        fire_err = 1'b1;
                    end else begin
                        sbrw_d    = (head.op == OP_WR);
                        sbadr_d   = {ch_base(head.ch), head.addr};
                        sbdat_o_d = (head.op == OP_WR) ? head.data : 8'h00;
                        state_d   = STROBE;
                    end
                end
            end
            STROBE: begin
                sbstb_d = 1'b1;
`ifdef SB_SEQ_ACK_TIMEOUT_EN
                if (sbstb_q) tmo_cnt_d = tmo_cnt_q + TW'(1);
`endif
                if (sbstb_q && bus.sback) begin
                    sbstb_d = 1'b0;
                    if (op_q == OP_POLL) begin
                        if (((bus.sbdat_i ^ match_q) & mask_q) == 8'h00) begin
                            fire      = 1'b1;
                            fire_data = bus.sbdat_i;
                        end else if (poll_cnt_q == PC_W'(POLL_MAX - 1)) begin
                            fire      = 1'b1;
                            fire_err  = 1'b1;
                            fire_data = bus.sbdat_i;
                        end else begin
                            poll_cnt_d = poll_cnt_q + PC_W'(1);
                            state_d    = GAP;
                        end
                    end else begin
                        fire      = 1'b1;
                        fire_data = (op_q == OP_RD) ? bus.sbdat_i : 8'h00;
                    end
                end
`ifdef SB_SEQ_ACK_TIMEOUT_EN
                else if (sbstb_q && tmo_cnt_q == TW'(TIMEOUT_CYCLES - 1)) begin
                    sbstb_d  = 1'b0;
                    fire     = 1'b1;
                    fire_err = 1'b1;
                end
`endif
            end
            // the strobe rises straight out of GAP so a poll retry has exactly one low cycle
            GAP: begin
                sbstb_d = 1'b1;
                state_d = STROBE;
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (fire) begin
            rsp_valid_d = 1'b1;
            rsp_data_d  = fire_data;
            rsp_err_d   = fire_err;
            state_d     = RESP;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            op_q        <= 2'b00;
            match_q     <= 8'h00;
            mask_q      <= 8'h00;
            poll_cnt_q  <= '0;
            sbstb_q     <= 1'b0;
            sbrw_q      <= 1'b0;
            sbadr_q     <= 8'h00;
            sbdat_o_q   <= 8'h00;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= 8'h00;
            rsp_err_q   <= 1'b0;
`ifdef SB_SEQ_ACK_TIMEOUT_EN
            tmo_cnt_q   <= '0;
`endif
        end else begin
            state_q     <= state_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            op_q        <= op_d;
            match_q     <= match_d;
            mask_q      <= mask_d;
            poll_cnt_q  <= poll_cnt_d;
            sbstb_q     <= sbstb_d;
            sbrw_q      <= sbrw_d;
            sbadr_q     <= sbadr_d;
            sbdat_o_q   <= sbdat_o_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
            rsp_err_q   <= rsp_err_d;
`ifdef SB_SEQ_ACK_TIMEOUT_EN
            tmo_cnt_q   <= tmo_cnt_d;
`endif
        end
    end

    assign bus.cmd_ready = !full;
    assign bus.busy      = !empty || (state_q != IDLE);
    assign bus.sbstb     = sbstb_q;
    assign bus.sbrw      = sbrw_q;
    assign bus.sbadr     = sbadr_q;
    assign bus.sbdat_o   = sbdat_o_q;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_data  = rsp_data_q;
    assign bus.rsp_err   = rsp_err_q;
endmodule

// File: tb/tb_sb_cmd_sequencer.sv
// Bench for sb_cmd_sequencer: directed + random commands against a queue-based reference model,
// with a behavioural hard-IP slave that acks strobes and backs reads with a byte memory.
module tb_sb_cmd_sequencer;
    localparam int unsigned DEPTH    = 4;
    localparam int unsigned NUM_CH   = 2;
    localparam int unsigned CH_W     = 1;
    localparam int unsigned POLL_MAX = 1023;

    typedef struct { logic [7:0] adr; logic rw; logic [7:0] dat; } bus_t;
    typedef struct { logic [7:0] data; logic err; } rsp_t;

    logic clock   = 1'b0;
    logic reset_n = 1'b1;
    always #5 clock = ~clock;

    sb_cmd_sequencer_if #(.CH_W(CH_W)) bif ();

    sb_cmd_sequencer #(.DEPTH(DEPTH), .NUM_CH(NUM_CH)) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bif.master)
    );

    int         n_asrt = 0;
    int         n_fail = 0;
    logic [3:0] ch_base_tb [2] = '{4'h1, 4'h3};
    logic [7:0] bus_mem [256];
    logic [7:0] ref_mem [256];
    bus_t       exp_bus [$];
    rsp_t       exp_rsp [$];
    logic [7:0] poll_plan [$];
    logic [7:0] poll_q [$];
    int         gap_q [$];
    int         ack_lat  = 0;
    bit         hold_ack = 1'b0;
    int         wait_cnt = 0;
    int         low_run  = 0;
    int         hi_run   = 0;
    int         last_hi  = 0;
    logic       prev_stb = 1'b0;
    logic [16:0] prev_bus = '0;
    bus_t       mon_b;
    rsp_t       mon_r;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_asrt++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // response checker, strobe shape tracker and hard-IP slave
    always @(negedge clock) begin
        if (!reset_n) begin
            bif.sback = 1'b0;
            wait_cnt  = 0;
            prev_stb  = 1'b0;
            low_run   = 0;
        end else begin
            if (bif.rsp_valid) begin
                chk("rsp_expected", 32'(exp_rsp.size() > 0), 32'd1);
                if (exp_rsp.size() > 0) begin
                    mon_r = exp_rsp.pop_front();
                    chk("rsp_data", 32'(bif.rsp_data), 32'(mon_r.data));
                    chk("rsp_err", 32'(bif.rsp_err), 32'(mon_r.err));
                end
            end
            if (bif.sbstb && prev_stb)
                chk("bus_stable", 32'({bif.sbadr, bif.sbrw, bif.sbdat_o}), 32'(prev_bus));
            if (bif.sbstb && !prev_stb) begin
                gap_q.push_back(low_run);
                hi_run = 0;
            end
            if (bif.sbstb) begin
                hi_run++;
                low_run = 0;
            end else begin
                if (prev_stb) last_hi = hi_run;
                low_run++;
            end
            prev_stb = bif.sbstb;
            prev_bus = {bif.sbadr, bif.sbrw, bif.sbdat_o};

            if (bif.sbstb && !hold_ack && !bif.sback) begin
                if (wait_cnt >= ack_lat) begin
                    chk("bus_expected", 32'(exp_bus.size() > 0), 32'd1);
                    if (exp_bus.size() > 0) begin
                        mon_b = exp_bus.pop_front();
                        chk("bus_adr", 32'(bif.sbadr), 32'(mon_b.adr));
                        chk("bus_rw", 32'(bif.sbrw), 32'(mon_b.rw));
                        chk("bus_dat", 32'(bif.sbdat_o), 32'(mon_b.dat));
                    end
                    if (poll_q.size() > 0) bif.sbdat_i = poll_q.pop_front();
                    else                   bif.sbdat_i = bus_mem[bif.sbadr];
                    if (bif.sbrw) bus_mem[bif.sbadr] = bif.sbdat_o;
                    bif.sback = 1'b1;
                    wait_cnt  = 0;
                end else begin
                    wait_cnt++;
                end
            end else begin
                bif.sback = 1'b0;
                if (!bif.sbstb) wait_cnt = 0;
            end
        end
    end

    task automatic send(input logic [1:0] op, input logic [CH_W-1:0] ch, input logic [3:0] addr,
                        input logic [7:0] data, input logic [7:0] mask);
        logic [7:0] a8;
        logic [7:0] v;
        logic [7:0] last;
        bit         matched;
        int         guard;
        a8 = {ch_base_tb[ch], addr};
        matched = 1'b0;
        last    = 8'h00;
        guard   = 0;
        if (op == 2'b11 || 32'(ch) >= NUM_CH) begin
            exp_rsp.push_back('{data: 8'h00, err: 1'b1});
        end else if (op == 2'b00) begin
            exp_bus.push_back('{adr: a8, rw: 1'b1, dat: data});
            ref_mem[a8] = data;
            exp_rsp.push_back('{data: 8'h00, err: 1'b0});
        end else if (op == 2'b01) begin
            exp_bus.push_back('{adr: a8, rw: 1'b0, dat: 8'h00});
            exp_rsp.push_back('{data: ref_mem[a8], err: 1'b0});
        end else begin
            for (int i = 0; i < int'(POLL_MAX) && !matched; i++) begin
                v = (i < poll_plan.size()) ? poll_plan[i] : ref_mem[a8];
                exp_bus.push_back('{adr: a8, rw: 1'b0, dat: 8'h00});
                last = v;
                if (((v ^ data) & mask) == 8'h00) matched = 1'b1;
            end
            exp_rsp.push_back('{data: last, err: !matched});
            poll_q = poll_plan;
            poll_plan.delete();
        end
        while (!bif.cmd_ready && guard < 2000) begin
            @(negedge clock);
            guard++;
        end
        chk("cmd_ready_wait", 32'(bif.cmd_ready), 32'd1);
        bif.cmd_valid = 1'b1;
        bif.cmd_op    = op;
        bif.cmd_ch    = ch;
        bif.cmd_addr  = addr;
        bif.cmd_data  = data;
        bif.cmd_mask  = mask;
        @(posedge clock);
        #1;
        bif.cmd_valid = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int max_cyc);
        int n;
        n = 0;
        while ((exp_rsp.size() != 0 || bif.busy) && n < max_cyc) begin
            @(negedge clock);
            n++;
        end
        chk({tag, "_rsp_left"}, 32'(exp_rsp.size()), 32'd0);
        chk({tag, "_bus_left"}, 32'(exp_bus.size()), 32'd0);
    endtask

    task automatic chk_rst_outputs(input string tag);
        chk(tag, 32'({bif.sbstb, bif.sbrw, bif.sbadr, bif.sbdat_o,
                      bif.rsp_valid, bif.rsp_data, bif.rsp_err, bif.busy}), 32'd0);
    endtask

    initial begin
        int guard;
        bif.cmd_valid = 1'b0;
        bif.cmd_op    = 2'b00;
        bif.cmd_ch    = '0;
        bif.cmd_addr  = 4'h0;
        bif.cmd_data  = 8'h00;
        bif.cmd_mask  = 8'h00;
        bif.sbdat_i   = 8'h00;
        bif.sback     = 1'b0;
        for (int i = 0; i < 256; i++) begin
            bus_mem[i] = 8'($urandom);
            ref_mem[i] = bus_mem[i];
        end

        // reset values
        #2 reset_n = 1'b0;
        #1 chk_rst_outputs("reset_outputs");
        repeat (3) @(negedge clock);
        reset_n = 1'b1;
        @(negedge clock);
        chk("reset_cmd_ready", 32'(bif.cmd_ready), 32'd1);
        chk("reset_busy", 32'(bif.busy), 32'd0);

        // write ch1 addr 8, strobe latency from cmd_valid into an idle block
        ack_lat = 3;
        send(2'b00, 1'b1, 4'h8, 8'hA5, 8'h00);
        @(negedge clock);
        chk("lat_stb_n0", 32'(bif.sbstb), 32'd0);
        @(negedge clock);
        chk("lat_stb_n1", 32'(bif.sbstb), 32'd0);
        @(negedge clock);
        chk("lat_stb_n2", 32'(bif.sbstb), 32'd1);
        chk("wr_sbadr", 32'(bif.sbadr), 32'h38);
        chk("wr_sbrw", 32'(bif.sbrw), 32'd1);
        chk("wr_sbdat_o", 32'(bif.sbdat_o), 32'hA5);
        wait_done("write", 100);

        // read ch0 addr 6
        ack_lat = 1;
        bus_mem[8'h16] = 8'h5C;
        ref_mem[8'h16] = 8'h5C;
        send(2'b01, 1'b0, 4'h6, 8'h00, 8'h00);
        wait_done("read", 100);
        chk("read_hold", 32'(bif.rsp_data), 32'h5C);

        // poll mask 80 match 00 against 80,80,00
        ack_lat = 0;
        gap_q.delete();
        poll_plan = '{8'h80, 8'h80, 8'h00};
        send(2'b10, 1'b0, 4'h2, 8'h00, 8'h80);
        wait_done("poll", 200);
        chk("poll_strobes", 32'(gap_q.size()), 32'd3);
        if (gap_q.size() == 3) begin
            chk("poll_gap1", 32'(gap_q[1]), 32'd1);
            chk("poll_gap2", 32'(gap_q[2]), 32'd1);
        end

        // illegal opcode: error response, no bus cycle
        send(2'b11, 1'b1, 4'h4, 8'hFF, 8'hFF);
        wait_done("illegal", 50);

        // poll that never matches runs POLL_MAX reads then errors with the last value
        bus_mem[8'h33] = 8'h0F;
        ref_mem[8'h33] = 8'h0F;
        send(2'b10, 1'b1, 4'h3, 8'hF0, 8'hFF);
        wait_done("poll_max", 5000);

        // backpressure: DEPTH queued plus one in flight while sback is withheld
        hold_ack = 1'b1;
        for (int i = 0; i < int'(DEPTH) + 1; i++)
            send(2'b00, 1'(i), 4'(i + 4), 8'($urandom), 8'h00);
        @(negedge clock);
        chk("full_cmd_ready", 32'(bif.cmd_ready), 32'd0);
        chk("full_busy", 32'(bif.busy), 32'd1);
        hold_ack = 1'b0;
        wait_done("full_drain", 200);

        // random write/read/illegal traffic
        for (int n = 0; n < 40; n++) begin
            int unsigned r;
            r = $urandom_range(0, 9);
            ack_lat = int'($urandom_range(0, 3));
            send((r < 5) ? 2'b00 : (r < 9) ? 2'b01 : 2'b11, 1'($urandom),
                 4'($urandom_range(0, 3)), 8'($urandom), 8'h00);
            repeat ($urandom_range(0, 2)) @(negedge clock);
        end
        wait_done("random", 2000);

        // reset during a strobe with commands queued
        hold_ack = 1'b1;
        ack_lat  = 0;
        for (int i = 0; i < 3; i++) send(2'b01, 1'b0, 4'(i), 8'h00, 8'h00);
        guard = 0;
        while (!bif.sbstb && guard < 50) begin
            @(negedge clock);
            guard++;
        end
        chk("mid_rst_strobe_seen", 32'(bif.sbstb), 32'd1);
        reset_n = 1'b0;
        exp_rsp.delete();
        exp_bus.delete();
        #1 chk_rst_outputs("mid_rst_outputs");
        hold_ack = 1'b0;
        repeat (2) @(negedge clock);
        reset_n = 1'b1;
        repeat (6) @(negedge clock);
        chk("mid_rst_cmd_ready", 32'(bif.cmd_ready), 32'd1);
        chk("mid_rst_busy", 32'(bif.busy), 32'd0);
        chk("mid_rst_sbstb", 32'(bif.sbstb), 32'd0);
        send(2'b00, 1'b0, 4'hC, 8'h3C, 8'h00);
        send(2'b01, 1'b0, 4'hC, 8'h00, 8'h00);
        wait_done("post_rst", 100);

`ifdef SB_SEQ_ACK_TIMEOUT_EN
        // ack timeout: strobe held for 255 cycles, error response, next command proceeds
        hold_ack = 1'b1;
        send(2'b01, 1'b0, 4'h1, 8'h00, 8'h00);
        void'(exp_bus.pop_back());
        void'(exp_rsp.pop_back());
        exp_rsp.push_back('{data: 8'h00, err: 1'b1});
        wait_done("timeout", 1000);
        chk("timeout_strobe_len", 32'(last_hi), 32'd255);
        hold_ack = 1'b0;
        send(2'b00, 1'b1, 4'h1, 8'h77, 8'h00);
        wait_done("after_timeout", 100);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
